// File: rtl/valve_demux_scheduler_pkg.sv
// Shared types and constants for the valve demux scheduler slice.
package valve_pkg;

    localparam int unsigned NUM_VALVE_CH = 4;
    localparam int unsigned SEL_W        = 4;
    localparam int unsigned IDX_W        = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACTIVE,
        ST_GUARD
    } state_t;

    function automatic logic [NUM_VALVE_CH-1:0] onehot4(input logic [IDX_W-1:0] idx);
        return NUM_VALVE_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/valve_demux_scheduler_if.sv
// Requester/demux bundle around the scheduler; master is the scheduler side.
interface valve_demux_scheduler_if #(
    parameter int unsigned DUR_W = 16
);
    import valve_pkg::*;

    logic [NUM_VALVE_CH-1:0]       req;
    logic [NUM_VALVE_CH*DUR_W-1:0] dur;
    logic [SEL_W-1:0]              sel;
    logic                          en;
    logic [NUM_VALVE_CH-1:0]       grant;
    logic [NUM_VALVE_CH-1:0]       done;
    logic                          busy;

    modport master (input req, dur, output sel, en, grant, done, busy);
    modport slave  (output req, dur, input sel, en, grant, done, busy);

endinterface

// File: rtl/valve_demux_scheduler_rr_arbiter4.sv
// Combinational 4-way round-robin pick, searching upward from ptr.
module rr_arbiter4
    import valve_pkg::*;
(
    input  logic [NUM_VALVE_CH-1:0] req,
    input  logic [IDX_W-1:0]        ptr,
    output logic [NUM_VALVE_CH-1:0] winner_c,
    output logic [IDX_W-1:0]        idx_c,
    output logic                    any_c
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        any_c = 1'b0;
        idx_c = '0;
        cand  = '0;
        for (int i = 0; i < NUM_VALVE_CH; i++) begin
            cand = ptr + IDX_W'(i);
            if (!any_c && req[cand]) begin
                any_c = 1'b1;
                idx_c = cand;
            end
        end
        winner_c = any_c ? onehot4(idx_c) : '0;
    end

endmodule

// File: rtl/valve_demux_scheduler.sv
// Shares one 1-to-4 valve demux between four requesters with
// break-before-make sequencing: setup, dwell, then a guard interval.
module valve_demux_scheduler
    import valve_pkg::*;
#(
    parameter int unsigned DUR_W        = 16,
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    valve_demux_scheduler_if.master bus
);

    state_t                  state_q, state_d;
    logic [DUR_W-1:0]        cnt_q, cnt_d;
    logic [DUR_W-1:0]        dur_q, dur_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        own_q, own_d;
    logic [NUM_VALVE_CH-1:0] grant_q, grant_d;
    logic [NUM_VALVE_CH-1:0] done_q, done_d;
    logic                    en_q, en_d;
    logic                    busy_q, busy_d;

    logic [NUM_VALVE_CH-1:0] win_c;
    logic [IDX_W-1:0]        win_idx_c;
    logic                    win_any_c;
    logic                    expire_c;
    logic                    owner_req_c;

    rr_arbiter4 u_arb (
        .req      (bus.req),
        .ptr      (ptr_q),
        .winner_c (win_c),
        .idx_c    (win_idx_c),
        .any_c    (win_any_c)
    );

    assign expire_c    = (cnt_q == DUR_W'(1));
    assign owner_req_c = bus.req[own_q];

    // Next-state, counter and output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dur_d   = dur_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        grant_d = grant_q;
        done_d  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (win_any_c) begin
                    own_d   = win_idx_c;
                    grant_d = win_c;
                    ptr_d   = win_idx_c + IDX_W'(1);
                    cnt_d   = DUR_W'(SETUP_CYCLES);
                    state_d = ST_SETUP;
                    for (int k = 0; k < NUM_VALVE_CH; k++) begin
                        if (win_idx_c == IDX_W'(k)) dur_d = bus.dur[k*DUR_W +: DUR_W];
                    end
                end
            end
            ST_SETUP: begin
                if (!owner_req_c) begin
                    state_d = ST_GUARD;
                    cnt_d   = DUR_W'(GUARD_CYCLES);
                    grant_d = '0;
                end else if (expire_c) begin
                    if (dur_q == '0) begin
                        state_d = ST_GUARD;
                        cnt_d   = DUR_W'(GUARD_CYCLES);
                        grant_d = '0;
                        done_d  = onehot4(own_q);
                    end else begin
                        state_d = ST_ACTIVE;
                        cnt_d   = dur_q;
                    end
                end else begin
                    cnt_d = cnt_q - DUR_W'(1);
                end
            end
            ST_ACTIVE: begin
                // Withdrawal wins over a coincident expiry: no completion pulse
                if (!owner_req_c || expire_c) begin
                    state_d = ST_GUARD;
                    cnt_d   = DUR_W'(GUARD_CYCLES);
                    grant_d = '0;
                    if (owner_req_c) done_d = onehot4(own_q);
                end else begin
                    cnt_d = cnt_q - DUR_W'(1);
                end
            end
            ST_GUARD: begin
                if (expire_c) state_d = ST_IDLE;
                else          cnt_d   = cnt_q - DUR_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign en_d   = (state_d == ST_ACTIVE);
    assign busy_d = (state_d != ST_IDLE);

    // State and registered outputs; reset drops en without waiting for a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dur_q   <= '0;
            ptr_q   <= '0;
            own_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dur_q   <= dur_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.sel   = SEL_W'(own_q);
    assign bus.en    = en_q;
    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;

endmodule
